// File: rtl/line_gen_stream_pkg.sv
// Shared types for the Bresenham line streamer.
// State encoding and the per-step datapath bundle.
package line_pkg;

    localparam int DEF_COORD_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [DEF_COORD_W-1:0]   x;
        logic [DEF_COORD_W-1:0]   y;
        logic signed [DEF_COORD_W+1:0] err;
    } line_step_t;

endpackage

// File: rtl/line_gen_stream_step.sv
// One Bresenham step: decides x/y moves from the
// doubled error term and returns the updated point.
module line_step #(
    parameter int COORD_W = 8
) (
    input  logic [COORD_W-1:0]        x,
    input  logic [COORD_W-1:0]        y,
    input  logic signed [COORD_W+1:0] err,
    input  logic signed [COORD_W:0]   dx,
    input  logic signed [COORD_W:0]   dy,
    input  logic                      sx_neg,
    input  logic                      sy_neg,
    output logic [COORD_W-1:0]        nx,
    output logic [COORD_W-1:0]        ny,
    output logic signed [COORD_W+1:0] nerr
);

    logic signed [COORD_W+2:0] e2;
    logic signed [COORD_W+2:0] dx3;
    logic signed [COORD_W+2:0] dy3;
    logic signed [COORD_W+1:0] dx2;
    logic signed [COORD_W+1:0] dy2;
    logic                      step_x;
    logic                      step_y;

    // Both moves are judged against the same e2 so a diagonal step is one cycle
    always_comb begin
        e2     = {err, 1'b0};
        dx3    = {{2{dx[COORD_W]}}, dx};
        dy3    = {{2{dy[COORD_W]}}, dy};
        dx2    = {dx[COORD_W], dx};
        dy2    = {dy[COORD_W], dy};
        step_x = (e2 >= dy3);
        step_y = (e2 <= dx3);
        nerr   = err + (step_x ? dy2 : '0) + (step_y ? dx2 : '0);
        nx     = x;
        ny     = y;
        if (step_x) nx = sx_neg ? x - 1'b1 : x + 1'b1;
        if (step_y) ny = sy_neg ? y - 1'b1 : y + 1'b1;
    end

endmodule

// File: rtl/line_gen_stream.sv
// Bresenham line streamer: one segment in, every point
// out on a valid/ready stream with last flag and abort.
module line_gen_stream
    import line_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] stax,
    input  logic [COORD_W-1:0] stay,
    input  logic [COORD_W-1:0] endx,
    input  logic [COORD_W-1:0] endy,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_last,
    output logic               done,
    output logic               busy
);

    state_t state, state_nx;

    logic [COORD_W-1:0]        x, y, x1, y1;
    logic signed [COORD_W:0]   dx, dy;
    logic signed [COORD_W+1:0] err;
    logic                      sx_neg, sy_neg;

    logic [COORD_W-1:0]        nx, ny;
    logic signed [COORD_W+1:0] nerr;

    logic                      accept;
    logic                      hs;
    logic                      advance;

    logic [COORD_W-1:0]        ld_dxa, ld_dya;
    logic                      ld_xneg, ld_yneg;

    line_step #(.COORD_W(COORD_W)) u_step (
        .x      (x),
        .y      (y),
        .err    (err),
        .dx     (dx),
        .dy     (dy),
        .sx_neg (sx_neg),
        .sy_neg (sy_neg),
        .nx     (nx),
        .ny     (ny),
        .nerr   (nerr)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: abort beats a simultaneous last-point handshake
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (in_valid && in_ready) state_nx = RUN;
            RUN: begin
                if (abort)                      state_nx = IDLE;
                else if (out_ready && out_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stream outputs and handshake qualifiers decoded from state
    always_comb begin
        out_valid = (state == RUN);
        busy      = (state != IDLE);
        out_last  = (state == RUN) && (x == x1) && (y == y1);
        out_x     = x;
        out_y     = y;
        accept    = (state == IDLE) && in_valid && in_ready;
        hs        = (state == RUN) && out_ready;
        advance   = hs && !abort && !out_last;
    end

    // Absolute deltas and directions of the offered segment
    always_comb begin
        ld_xneg = (endx < stax);
        ld_yneg = (endy < stay);
        ld_dxa  = ld_xneg ? stax - endx : endx - stax;
        ld_dya  = ld_yneg ? stay - endy : endy - stay;
    end

    // Operand registers: load on accept, step on non-final handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x      <= '0;
            y      <= '0;
            x1     <= '0;
            y1     <= '0;
            dx     <= '0;
            dy     <= '0;
            err    <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
        end else if (accept) begin
            x      <= stax;
            y      <= stay;
            x1     <= endx;
            y1     <= endy;
            dx     <= {1'b0, ld_dxa};
            dy     <= -$signed({1'b0, ld_dya});
            err    <= $signed({2'b00, ld_dxa}) - $signed({2'b00, ld_dya});
            sx_neg <= ld_xneg;
            sy_neg <= ld_yneg;
        end else if (advance) begin
            x      <= nx;
            y      <= ny;
            err    <= nerr;
        end
    end

    // Registered in_ready and end-of-segment pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
            done     <= 1'b0;
        end else begin
            in_ready <= (state_nx == IDLE);
            done     <= hs && !abort && out_last;
        end
    end

endmodule
